multi_channel_fifo: RTL and testbench

Parametrised successor to the single-channel FIFO. It provides NUM_CH independent synchronous FIFOs that share one clock and reset, one per systolic-array row or column feed. It adds:
- selectable first-word-fall-through (FWFT) or registered-read mode;
- exact occupancy counts and programmable almost-full / almost-empty flags;
- write-through-when-full on a simultaneous pop;
- sticky overflow/underflow error flags.

It sits between the host/load path and the array edge, buffering per-lane operand streams.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_channel.sv | 102 ++++++++++
 rtl/multi_channel_fifo.sv | 60 ++++++
 tb/tb_multi_channel_fifo.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared sizing helpers and default levels for multi_channel_fifo
// Purpose: count-width, default almost-full/almost-empty levels, channel slice offset.
package fifo_pkg;

  localparam int DEFAULT_DEPTH    = 16;
  localparam int DEFAULT_AE_LEVEL = 2;

  // Occupancy runs 0..DEPTH inclusive, so one bit more than the pointer.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int default_af_level(input int depth);
    return depth - 2;
  endfunction

  // Low bit of channel ch in a bus packed as {ch[N-1], ..., ch[0]}.
  function automatic int ch_lo(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/fifo_channel.sv
// rtl/fifo_channel.sv - one synchronous FIFO channel with flags, sticky errors and FWFT/registered read
// Ports: clk, reset (sync, active-high); wr_en/wr_data push; rd_en pop;
//        rd_data/rd_valid read path; count occupancy; empty/full/almost_* flags;
//        overflow/underflow sticky errors.
module fifo_channel
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = default_af_level(DEPTH),
  parameter int AE_LEVEL   = DEFAULT_AE_LEVEL
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_valid,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_empty,
  output logic                          almost_full,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         cnt;
  logic                  pop_ok;
  logic                  push_ok;

  // A full channel still takes a push when a pop frees the head slot in the
  // same cycle. An empty channel never bypasses: the pop is simply rejected.
  assign pop_ok  = rd_en && (cnt != '0);
  assign push_ok = wr_en && ((cnt != DEPTH_C) || pop_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (wr_en && !push_ok)     overflow  <= 1'b1;
      if (rd_en && (cnt == '0))  underflow <= 1'b1;
    end
  end

  // Storage is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem[wr_ptr] <= wr_data;
  end

  assign count        = cnt;
  assign empty        = (cnt == '0);
  assign full         = (cnt == DEPTH_C);
  assign almost_full  = (cnt >= AF_C);
  assign almost_empty = (cnt <= AE_C);

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data  = mem[rd_ptr];
      assign rd_valid = !empty;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] rd_q;
      logic                  rv_q;
      // On write-through at full, wr_ptr == rd_ptr; the non-blocking read
      // returns the old head before the new word lands.
      always_ff @(posedge clk) begin
        if (reset) begin
          rd_q <= '0;
          rv_q <= 1'b0;
        end else begin
          rv_q <= pop_ok;
          if (pop_ok) rd_q <= mem[rd_ptr];
        end
      end
      assign rd_data  = rd_q;
      assign rd_valid = rv_q;
    end
  endgenerate

endmodule

// File: rtl/multi_channel_fifo.sv
// rtl/multi_channel_fifo.sv - NUM_CH independent FIFO channels sharing clock and reset
// Ports: clk, reset (sync, active-high); per-channel wr_en/rd_en bits; wr_data,
//        rd_data and count packed with channel c at [c*W +: W]; per-channel
//        status and sticky error bits.
module multi_channel_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int NUM_CH     = 4,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = default_af_level(DEPTH),
  parameter int AE_LEVEL   = DEFAULT_AE_LEVEL
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_CH-1:0]                    wr_en,
  input  logic [NUM_CH*DATA_WIDTH-1:0]         wr_data,
  input  logic [NUM_CH-1:0]                    rd_en,
  output logic [NUM_CH*DATA_WIDTH-1:0]         rd_data,
  output logic [NUM_CH-1:0]                    rd_valid,
  output logic [NUM_CH*count_width(DEPTH)-1:0] count,
  output logic [NUM_CH-1:0]                    empty,
  output logic [NUM_CH-1:0]                    full,
  output logic [NUM_CH-1:0]                    almost_empty,
  output logic [NUM_CH-1:0]                    almost_full,
  output logic [NUM_CH-1:0]                    overflow,
  output logic [NUM_CH-1:0]                    underflow
);

  localparam int CW = count_width(DEPTH);

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      fifo_channel #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .FWFT       (FWFT),
        .AF_LEVEL   (AF_LEVEL),
        .AE_LEVEL   (AE_LEVEL)
      ) u_ch (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en[c]),
        .wr_data      (wr_data[ch_lo(c, DATA_WIDTH) +: DATA_WIDTH]),
        .rd_en        (rd_en[c]),
        .rd_data      (rd_data[ch_lo(c, DATA_WIDTH) +: DATA_WIDTH]),
        .rd_valid     (rd_valid[c]),
        .count        (count[ch_lo(c, CW) +: CW]),
        .empty        (empty[c]),
        .full         (full[c]),
        .almost_empty (almost_empty[c]),
        .almost_full  (almost_full[c]),
        .overflow     (overflow[c]),
        .underflow    (underflow[c])
      );
    end
  endgenerate

endmodule

// File: tb/tb_multi_channel_fifo.sv
// tb/tb_multi_channel_fifo.sv - self-checking bench for multi_channel_fifo (registered and FWFT builds)
module tb_multi_channel_fifo;

  localparam int DW = 8;
  localparam int D  = 16;
  localparam int NC = 4;
  localparam int CW = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [NC-1:0]     wr_en;
  logic [NC*DW-1:0]  wr_data;
  logic [NC-1:0]     rd_en;

  logic [NC*DW-1:0]  r_rd_data, f_rd_data;
  logic [NC-1:0]     r_rd_valid, f_rd_valid;
  logic [NC*CW-1:0]  r_count, f_count;
  logic [NC-1:0]     r_empty, f_empty, r_full, f_full;
  logic [NC-1:0]     r_ae, f_ae, r_af, f_af;
  logic [NC-1:0]     r_of, f_of, r_uf, f_uf;

  always #5 clk = ~clk;

  multi_channel_fifo #(.DATA_WIDTH(DW), .DEPTH(D), .NUM_CH(NC), .FWFT(0)) u_reg (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(r_rd_data), .rd_valid(r_rd_valid), .count(r_count),
    .empty(r_empty), .full(r_full), .almost_empty(r_ae), .almost_full(r_af),
    .overflow(r_of), .underflow(r_uf)
  );

  multi_channel_fifo #(.DATA_WIDTH(DW), .DEPTH(D), .NUM_CH(NC), .FWFT(1)) u_fwft (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .count(f_count),
    .empty(f_empty), .full(f_full), .almost_empty(f_ae), .almost_full(f_af),
    .overflow(f_of), .underflow(f_uf)
  );

  // Reference model: one queue per channel plus sticky bits and the
  // registered-read output of the FWFT=0 build.
  logic [DW-1:0] mq [NC][$];
  logic          m_of [NC];
  logic          m_uf [NC];
  logic [DW-1:0] m_rd [NC];
  logic          m_rv [NC];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input logic rst, input logic [NC-1:0] we,
                              input logic [NC*DW-1:0] wd, input logic [NC-1:0] re);
    for (int c = 0; c < NC; c++) begin
      if (rst) begin
        mq[c].delete();
        m_of[c] = 1'b0;
        m_uf[c] = 1'b0;
        m_rd[c] = '0;
        m_rv[c] = 1'b0;
      end else begin
        int  n;
        logic pop, push;
        n    = mq[c].size();
        pop  = re[c] && (n > 0);
        push = we[c] && ((n < D) || pop);
        if (re[c] && n == 0) m_uf[c] = 1'b1;
        if (we[c] && !push)  m_of[c] = 1'b1;
        m_rv[c] = pop;
        if (pop)  m_rd[c] = mq[c].pop_front();
        if (push) mq[c].push_back(wd[c*DW +: DW]);
      end
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < NC; c++) begin
      int n;
      n = mq[c].size();
      check($sformatf("reg count[%0d]", c),  32'(r_count[c*CW +: CW]), 32'(n));
      check($sformatf("fwft count[%0d]", c), 32'(f_count[c*CW +: CW]), 32'(n));
      check($sformatf("empty[%0d]", c),  {30'd0, r_empty[c], f_empty[c]}, {30'd0, n == 0, n == 0});
      check($sformatf("full[%0d]", c),   {30'd0, r_full[c], f_full[c]},   {30'd0, n == D, n == D});
      check($sformatf("almost_empty[%0d]", c), {30'd0, r_ae[c], f_ae[c]}, {30'd0, n <= 2, n <= 2});
      check($sformatf("almost_full[%0d]", c),  {30'd0, r_af[c], f_af[c]}, {30'd0, n >= D-2, n >= D-2});
      check($sformatf("overflow[%0d]", c),  {30'd0, r_of[c], f_of[c]}, {30'd0, m_of[c], m_of[c]});
      check($sformatf("underflow[%0d]", c), {30'd0, r_uf[c], f_uf[c]}, {30'd0, m_uf[c], m_uf[c]});
      check($sformatf("reg rd_valid[%0d]", c), 32'(r_rd_valid[c]), 32'(m_rv[c]));
      check($sformatf("reg rd_data[%0d]", c),  32'(r_rd_data[c*DW +: DW]), 32'(m_rd[c]));
      check($sformatf("fwft rd_valid[%0d]", c), 32'(f_rd_valid[c]), 32'(n != 0));
      if (n != 0)
        check($sformatf("fwft rd_data[%0d]", c), 32'(f_rd_data[c*DW +: DW]), 32'(mq[c][0]));
    end
  endtask

  task automatic step(input logic rst, input logic [NC-1:0] we,
                      input logic [NC*DW-1:0] wd, input logic [NC-1:0] re);
    @(negedge clk);
    reset   = rst;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    @(posedge clk);
    model_update(rst, we, wd, re);
    #1;
    check_all();
  endtask

  task automatic random_phase(input int cycles, input int wr_pct, input int rd_pct);
    for (int i = 0; i < cycles; i++) begin
      logic [NC-1:0] we, re;
      for (int c = 0; c < NC; c++) begin
        we[c] = ($urandom_range(0, 99) < wr_pct);
        re[c] = ($urandom_range(0, 99) < rd_pct);
      end
      step($urandom_range(0, 99) == 0, we, 32'($urandom), re);
    end
  endtask

  initial begin
    reset   = 1'b1;
    wr_en   = '0;
    wr_data = '0;
    rd_en   = '0;

    // Reset held two cycles with every request asserted.
    step(1'b1, '1, 32'($urandom), '1);
    step(1'b1, '1, 32'($urandom), '1);
    check("reset rd_data", 32'(r_rd_data), 32'd0);

    // Fill ch0 with 0x00..0x0F, one extra push, then drain past empty.
    for (int i = 0; i < D; i++) step(1'b0, 4'b0001, {24'd0, 8'(i)}, 4'b0000);
    check("ch0 full after fill", 32'(r_full[0]), 32'd1);
    step(1'b0, 4'b0001, {24'd0, 8'h10}, 4'b0000);
    for (int i = 0; i < D; i++) begin
      step(1'b0, 4'b0000, '0, 4'b0001);
      check("ch0 drain order", 32'(r_rd_data[7:0]), 32'(i));
    end
    step(1'b0, 4'b0000, '0, 4'b0001);
    step(1'b0, 4'b0000, '0, 4'b0000);

    // Write-through at full on ch1.
    for (int i = 0; i < D; i++) step(1'b0, 4'b0010, {16'd0, 8'($urandom), 8'd0}, 4'b0000);
    step(1'b0, 4'b0010, {16'd0, 8'hAA, 8'd0}, 4'b0010);
    for (int i = 0; i < D; i++) step(1'b0, 4'b0000, '0, 4'b0010);
    check("ch1 write-through 16th read", 32'(r_rd_data[15:8]), 32'hAA);

    // Wrap-around on ch2 at steady occupancy 3.
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0100, {8'd0, 8'($urandom), 16'd0}, 4'b0000);
    for (int i = 0; i < 40; i++) step(1'b0, 4'b0100, {8'd0, 8'($urandom), 16'd0}, 4'b0100);

    // FWFT visibility on empty ch3.
    step(1'b0, 4'b1000, {8'h55, 24'd0}, 4'b0000);
    check("ch3 fwft head", 32'(f_rd_data[31:24]), 32'h55);
    step(1'b0, 4'b0000, '0, 4'b0000);
    step(1'b0, 4'b0000, '0, 4'b1000);

    // Overflow ch0 while ch1..ch3 stream, then reset mid-stream.
    for (int i = 0; i < D + 4; i++)
      step(1'b0, {3'($urandom), 1'b1}, 32'($urandom), {3'($urandom), 1'b0});
    step(1'b1, '1, 32'($urandom), '1);
    step(1'b0, '0, '0, '0);

    random_phase(150, 80, 30);
    random_phase(150, 30, 80);
    random_phase(150, 60, 60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
